// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester round-robin arbiter in front of one shared combinational ALU
// One operation in flight: IDLE accepts, EXEC lets the ALU settle, RESP pulses the tagged response.
module alu_share_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [4:0]  req0_sa,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [4:0]  req1_sa,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_out,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_out,
  output logic        rsp1_zero,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [4:0]  alu_sa,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        tag_q, tag_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [4:0]  sa_q, sa_d;
  logic [31:0] res_out_q, res_out_d;
  logic        res_zero_q, res_zero_d;

  logic idle;
  logic gnt0;
  logic gnt1;

  // Requester 1 wins only when alone or when requester 0 was served last.
  assign idle = (state_q == IDLE);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
  assign gnt0 = req0_valid & ~gnt1;

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    ctrl_d       = ctrl_q;
    x_d          = x_q;
    y_d          = y_q;
    sa_d         = sa_q;
    res_out_d    = res_out_q;
    res_zero_d   = res_zero_q;
    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          state_d      = EXEC;
          last_grant_d = gnt1;
          tag_d        = gnt1;
          ctrl_d       = gnt1 ? req1_ctrl : req0_ctrl;
          x_d          = gnt1 ? req1_x    : req0_x;
          y_d          = gnt1 ? req1_y    : req0_y;
          sa_d         = gnt1 ? req1_sa   : req0_sa;
        end
      end
      EXEC: begin
        state_d    = RESP;
        res_out_d  = alu_out;
        res_zero_d = alu_zero;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tag_q        <= 1'b0;
      ctrl_q       <= 4'd0;
      x_q          <= 32'd0;
      y_q          <= 32'd0;
      sa_q         <= 5'd0;
      res_out_q    <= 32'd0;
      res_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      ctrl_q       <= ctrl_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sa_q         <= sa_d;
      res_out_q    <= res_out_d;
      res_zero_q   <= res_zero_d;
    end
  end

  assign alu_ctrl = ctrl_q;
  assign alu_x    = x_q;
  assign alu_y    = y_q;
  assign alu_sa   = sa_q;

  // Response pulse is decoded from state so an asynchronous reset kills it at once.
  assign rsp0_valid = (state_q == RESP) & ~tag_q;
  assign rsp1_valid = (state_q == RESP) &  tag_q;
  assign rsp0_out   = res_out_q;
  assign rsp0_zero  = res_zero_q;
  assign rsp1_out   = res_out_q;
  assign rsp1_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed bench for alu_share_arb with a small shared-ALU model
// ALU codes: 0 add, 1 sub, 2 and, 3 or, 5 arithmetic right shift of y by sa, others return 0.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_ctrl;
  logic [31:0] req0_x, req0_y;
  logic [4:0]  req0_sa;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_ctrl;
  logic [31:0] req1_x, req1_y;
  logic [4:0]  req1_sa;
  logic        rsp0_valid, rsp0_zero, rsp1_valid, rsp1_zero;
  logic [31:0] rsp0_out, rsp1_out;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_x, alu_y, alu_out;
  logic [4:0]  alu_sa;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_x(req0_x), .req0_y(req0_y), .req0_sa(req0_sa),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_x(req1_x), .req1_y(req1_y), .req1_sa(req1_sa),
    .rsp0_valid(rsp0_valid), .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_sa(alu_sa),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_out = alu_x + alu_y;
      4'd1:    alu_out = alu_x - alu_y;
      4'd2:    alu_out = alu_x & alu_y;
      4'd3:    alu_out = alu_x | alu_y;
      4'd5:    alu_out = $unsigned($signed(alu_y) >>> alu_sa);
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_ctrl = 0; req0_x = 0; req0_y = 0; req0_sa = 0;
    req1_valid = 0; req1_ctrl = 0; req1_x = 0; req1_y = 0; req1_sa = 0;
    step();
    step();
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_x", alu_x, 32'd0);
    chk("rst_rsp0_out", rsp0_out, 32'd0);

    // Contention straight out of reset: req0 ADD 1+1, req1 SRA 0x80000000 by 4.
    req0_valid = 1; req0_ctrl = 4'd0; req0_x = 32'd1; req0_y = 32'd1; req0_sa = 5'd0;
    req1_valid = 1; req1_ctrl = 4'd5; req1_x = 32'd0; req1_y = 32'h8000_0000; req1_sa = 5'd4;
    rst_n = 1'b1;
    #1;
    chk("c1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("c1_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("c1_exec_ready0", {31'd0, req0_ready}, 32'd0);
    chk("c1_exec_ready1", {31'd0, req1_ready}, 32'd0);
    chk("c1_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("c1_exec_alu_x", alu_x, 32'd1);
    chk("c1_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    req0_valid = 0;
    step();
    chk("c1_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("c1_resp_rsp0_out", rsp0_out, 32'd2);
    chk("c1_resp_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
    chk("c1_resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("c1_resp_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("c2_idle_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("c2_idle_ready1", {31'd0, req1_ready}, 32'd1);
    chk("c2_idle_alu_x_held", alu_x, 32'd1);
    step();
    chk("c2_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'd5);
    chk("c2_exec_alu_sa", {27'd0, alu_sa}, 32'd4);
    chk("c2_exec_alu_y", alu_y, 32'h8000_0000);
    req1_valid = 0;
    step();
    chk("c2_resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("c2_resp_rsp1_out", rsp1_out, 32'hF800_0000);
    chk("c2_resp_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
    chk("c2_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("c2_resp_rsp0_out_shared", rsp0_out, 32'hF800_0000);
    step();

    // Third contention round goes to req0 again; then req1 SUB 3-3 gives zero.
    req0_valid = 1; req0_ctrl = 4'd0; req0_x = 32'd2; req0_y = 32'd3;
    req1_valid = 1; req1_ctrl = 4'd1; req1_x = 32'd3; req1_y = 32'd3; req1_sa = 5'd0;
    #1;
    chk("c3_ready0", {31'd0, req0_ready}, 32'd1);
    chk("c3_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 0;
    step();
    chk("c3_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("c3_resp_rsp0_out", rsp0_out, 32'd5);
    step();
    chk("c4_idle_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    chk("c4_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'd1);
    req1_valid = 0;
    step();
    chk("c4_resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("c4_resp_rsp1_out", rsp1_out, 32'd0);
    chk("c4_resp_rsp1_zero", {31'd0, rsp1_zero}, 32'd1);
    chk("c4_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    step();

    // Undefined ctrl 0100 passes through; the ALU returns 0 with zero set.
    req0_valid = 1; req0_ctrl = 4'd4; req0_x = 32'hFFFF_FFFF; req0_y = 32'd0;
    step();
    chk("u_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'd4);
    req0_valid = 0;
    step();
    chk("u_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("u_resp_rsp0_out", rsp0_out, 32'd0);
    chk("u_resp_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
    step();

    // Simple ADD 5+7 on req0 alone.
    req0_valid = 1; req0_ctrl = 4'd0; req0_x = 32'd5; req0_y = 32'd7;
    step();
    chk("s_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("s_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    req0_valid = 0;
    step();
    chk("s_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("s_resp_rsp0_out", rsp0_out, 32'd12);
    chk("s_resp_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
    chk("s_resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    step();

    // Idle with nothing valid: no accept, alu_* and result hold.
    chk("i_ready0", {31'd0, req0_ready}, 32'd0);
    chk("i_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("i_alu_x_held", alu_x, 32'd5);
    chk("i_rsp0_out_held", rsp0_out, 32'd12);
    chk("i_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);

    // Reset during EXEC abandons the operation.
    req1_valid = 1; req1_ctrl = 4'd0; req1_x = 32'd9; req1_y = 32'd9;
    step();
    chk("r_exec_alu_x", alu_x, 32'd9);
    req1_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("r_alu_x", alu_x, 32'd0);
    chk("r_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("r_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("r_rsp1_out", rsp1_out, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_post_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      chk("r_post_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    end
    req1_valid = 1; req1_ctrl = 4'd0; req1_x = 32'd100; req1_y = 32'd23;
    #1;
    chk("r_next_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 0;
    chk("r_next_exec_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    step();
    chk("r_next_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("r_next_rsp1_out", rsp1_out, 32'd123);
    step();
    chk("r_next_done_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 Ports req0_valid / req1_valid, input, 1 each: requester 0/1 holds an ALU operation.
REQ-004 Ports req0_ready / req1_ready, output, 1 each: operation accepted this cycle; transfer when valid & ready.
REQ-005 Ports reqN_ctrl [3:0], reqN_x [31:0], reqN_y [31:0], reqN_sa [4:0] (N=0,1), input: operation code and operands; stable while reqN_valid is high.
REQ-006 Ports rspN_valid, output, 1 (N=0,1): one-cycle pulse carrying the result for requester N.
REQ-007 Ports rspN_out [31:0], rspN_zero [1], output (N=0,1): result word and zero flag; valid only while rspN_valid is high.
REQ-008 Ports alu_ctrl [3:0], alu_x [31:0], alu_y [31:0], alu_sa [4:0], output: registered drive to the shared ALU.
REQ-009 Ports alu_out [31:0], alu_zero [1], input: combinational result from the shared ALU.

Function
REQ-010 FSM states: IDLE, EXEC, RESP; exactly one operation outstanding at a time.
REQ-011 IDLE: reqN_ready is combinational, high only for the granted requester, and only in IDLE; both readys low in EXEC and RESP.
REQ-012 Grant, single request: the valid requester is granted.
REQ-013 Grant, both requests: the requester not granted last is granted (round-robin); the last_grant register updates on every accepted transfer.
REQ-014 Accept in cycle N:
- latch ctrl/x/y/sa into alu_* registers and the requester ID into a tag register;
- transition IDLE->EXEC.
REQ-015 EXEC (cycle N+1):
- alu_* stable;
- capture alu_out and alu_zero into result registers at the end of the cycle;
- transition EXEC->RESP.
REQ-016 RESP (cycle N+2):
- rspT_valid high for exactly one cycle, where T is the tag; the other rsp_valid stays low;
- transition RESP->IDLE.
REQ-017 Latency: request-accept to rsp_valid = 2 cycles; maximum throughput 1 operation per 3 cycles.
REQ-018 Responses carry no backpressure; the requester must sample in the rsp_valid cycle.
REQ-019 rspN_out/rspN_zero hold their last captured value outside rsp_valid; both rsp ports share the single result register.
REQ-020 ctrl values are passed to the ALU unmodified, including codes the ALU treats as undefined; whatever the ALU returns (0, zero=1) is reported.
REQ-021 alu_* registers hold their value after EXEC until the next accept.
REQ-022 A requester deasserting valid while not ready is ignored; no state change occurs.
REQ-023 Starvation bound: a continuously valid requester is accepted within 2 operations (6 cycles) from the point it first sees an IDLE cycle.

Reset
REQ-024 While rst_n=0, independent of clk:
- state = IDLE, last_grant = 1 (so requester 0 wins the first contention);
- tag = 0; alu_* = 0; result registers = 0;
- rsp0_valid = rsp1_valid = 0.
REQ-025 Reset asserted in EXEC or RESP abandons the operation; no rsp_valid is produced for it after rst_n deasserts.
REQ-026 The first accept may occur in the first clock edge after rst_n deasserts.

Verification
REQ-027 Simple op: req0 ctrl=0000, x=5, y=7 accepted at cycle N -> alu_ctrl=0000 at N+1; rsp0_valid=1, rsp0_out=12, rsp0_zero=0 at N+2; rsp1_valid=0 throughout.
REQ-028 Zero flag: req1 ctrl=0001, x=3, y=3 -> rsp1_valid at N+2 with rsp1_out=0, rsp1_zero=1.
REQ-029 Contention: both valid from the first cycle after reset, req0 ADD 1+1, req1 SRA y=0x80000000 sa=4 -> req0 accepted first (rsp0_out=2); req1 accepted 3 cycles later (rsp1_out=0xF8000000); a third simultaneous round grants req0 again.
REQ-030 Undefined ctrl: req0 ctrl=0100, x=0xFFFFFFFF -> rsp0_out=0, rsp0_zero=1.
REQ-031 Reset mid-op: assert rst_n=0 during EXEC -> all outputs 0 immediately; no rsp_valid after release; the next request completes normally with correct latency.
REQ-032 Handshake check: assert req valid during EXEC/RESP -> ready stays 0 until IDLE; operands remain unchanged on alu_* until the next accept.
